// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_if
//  Description : Pipeline control word shared by the rvga stages, plus the
//                data-memory req/ack bus between the memory stage and the
//                data memory.
//  Ports       : master modport (memory stage) drives dmem_req, dmem_we,
//                dmem_addr, dmem_wdata, dmem_be and samples dmem_rdata,
//                dmem_ack. The slave modport (data memory) is the mirror.
//  Revision    : 1.0 - initial release
// ============================================================================

// Control word carried between pipeline stages. For memory operations
// rd_data holds the effective byte address produced by execute.
typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] rd_data;
    logic [31:0] rs2_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;      // 0 = byte, 1 = half, 2 = word
    logic        mem_unsigned;
} rvga_cword;

interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [3:0]        dmem_be;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_be,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_be,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : Memory stage of the rvga pipeline. Turns ex_mem_cword into
//                mem_wb_cword; loads/stores go to data memory over a req/ack
//                handshake, load data is lane-selected and extended.
//                Non-memory control words pass through with 1 cycle latency.
//  Ports       : clk, rst_n (async, active low)
//                ex_mem_cword  - control word from execute (held while stalled)
//                mem_stall     - stall to upstream while an access is pending
//                mem_wb_cword  - control word to writeback (0 = bubble)
//                dmem          - data-memory bus (master side)
//                misalign_err  - 1-cycle pulse, misaligned access dropped
//                bus_err       - 1-cycle pulse, access aborted on timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    input  wire rvga_cword ex_mem_cword,
    output logic           mem_stall,
    output rvga_cword      mem_wb_cword,
    mem_access_if.master   dmem,
    output logic           misalign_err,
    output logic           bus_err
);

    localparam int             CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    rvga_cword         op_q, op_d;        // control word of the access in flight
    rvga_cword         wb_q, wb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    // ------------------------------------------------------------------
    // Decode of the incoming control word
    // ------------------------------------------------------------------
    logic              w_mem_op;
    logic              w_misaligned;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_lane;
    logic [DATA_W-1:0] w_st_wdata;
    logic [3:0]        w_st_be;

    assign w_addr   = ex_mem_cword.rd_data[ADDR_W-1:0];
    assign w_lane   = ex_mem_cword.rd_data[1:0];
    assign w_mem_op = ex_mem_cword.mem_read | ex_mem_cword.mem_write;
    assign w_misaligned = ((ex_mem_cword.mem_size == 2'd1) && w_lane[0]) ||
                          ((ex_mem_cword.mem_size == 2'd2) && (w_lane != 2'b00));

    // Store data is replicated across lanes so the memory only needs the
    // byte enables to pick the right bytes.
    always_comb begin
        w_st_wdata = ex_mem_cword.rs2_data;
        w_st_be    = 4'b1111;
        case (ex_mem_cword.mem_size)
            2'd0: begin
                w_st_wdata = {4{ex_mem_cword.rs2_data[7:0]}};
                w_st_be    = 4'b0001 << w_lane;
            end
            2'd1: begin
                w_st_wdata = {2{ex_mem_cword.rs2_data[15:0]}};
                w_st_be    = 4'b0011 << w_lane;
            end
            default: begin
                w_st_wdata = ex_mem_cword.rs2_data;
                w_st_be    = 4'b1111;
            end
        endcase
    end

    // Select the addressed byte/half from the returned word and extend it.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] rdata,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lane, 3'b000} +: 8];
        h = rdata[{lane[1], 4'b0000} +: 16];
        case (size)
            2'd0:    res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        wb_d      = '0;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;
        mem_stall = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!w_mem_op) begin
                    wb_d = ex_mem_cword;
                end else if (w_misaligned) begin
                    // Dropped access: no bus traffic, no register write.
                    wb_d         = ex_mem_cword;
                    wb_d.rd_we   = 1'b0;
                    wb_d.rd_data = '0;
                    mis_d        = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    op_d      = ex_mem_cword;
                    we_d      = ex_mem_cword.mem_write;
                    addr_d    = {w_addr[ADDR_W-1:2], 2'b00};
                    wdata_d   = w_st_wdata;
                    be_d      = ex_mem_cword.mem_write ? w_st_be : 4'b1111;
                    cnt_d     = '0;
                    state_d   = S_BUSY;
                end
            end

            S_BUSY: begin
                if (dmem.dmem_ack) begin
                    // Stall releases in the ack cycle so execute advances on
                    // the same edge that retires the access.
                    wb_d = op_q;
                    if (!op_q.mem_write) begin
                        wb_d.rd_data = fmt_load(dmem.dmem_rdata, op_q.rd_data[1:0],
                                                op_q.mem_size, op_q.mem_unsigned);
                    end
                    state_d = S_IDLE;
                end else if (cnt_q == C_CNT_LAST) begin
                    wb_d       = op_q;
                    wb_d.rd_we = 1'b0;
                    berr_d     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wb_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wb_q    <= wb_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    // Request is a pure function of the state register, so an async reset
    // while BUSY removes it immediately.
    assign dmem.dmem_req   = (state_q == S_BUSY);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    assign mem_wb_cword = wb_q;
    assign misalign_err = mis_q;
    assign bus_err      = berr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access. Stimulus pushes expected
//                writeback words and bus requests into queues; a writeback
//                monitor and a data-memory responder pop and compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int TIMEOUT_CYC = 64;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    rvga_cword ex_mem_cword;
    rvga_cword mem_wb_cword;
    logic      mem_stall;
    logic      misalign_err;
    logic      bus_err;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) dmem ();

    mem_access #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_mem_cword (ex_mem_cword),
        .mem_stall    (mem_stall),
        .mem_wb_cword (mem_wb_cword),
        .dmem         (dmem),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        rvga_cword cw;
        bit        mis;
        bit        berr;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    // delay >= 0: ack in that BUSY cycle; -1: withhold (timeout expected);
    // -2: withhold, access will be killed by reset.
    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } rsp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    rsp_t     rsp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference load formatting by plain arithmetic on the returned word.
    function automatic logic [31:0] ref_load(logic [31:0] rd, int lane, int size, bit uns);
        longint v;
        if (size == 0) begin
            v = longint'(rd >> (8 * lane)) % 256;
            if (!uns && v >= 128) v -= 256;
        end else if (size == 1) begin
            v = longint'(rd >> (16 * (lane / 2))) % 65536;
            if (!uns && v >= 32768) v -= 65536;
        end else begin
            v = longint'(rd);
        end
        return v[31:0];
    endfunction

    function automatic rvga_cword mk_cw(int kind, int size, logic [31:0] addr,
                                        logic [31:0] rs2, bit uns);
        rvga_cword cw;
        cw              = '0;
        cw.pc           = {$urandom_range(1, 32'h0FFF_FFFF), 2'b00} | 32'h4;
        cw.rd_addr      = 5'($urandom);
        cw.rs2_data     = rs2;
        cw.rd_data      = addr;
        cw.mem_size     = 2'(size);
        cw.mem_unsigned = uns;
        cw.rd_we        = (kind != 2);
        cw.mem_read     = (kind == 1);
        cw.mem_write    = (kind == 2);
        return cw;
    endfunction

    // Issue one control word at posedge+1; returns at posedge+1 after it
    // has been consumed.
    task automatic issue(input rvga_cword cw, input int delay, input logic [31:0] rdata);
        wb_exp_t  e;
        req_exp_t rq;
        rsp_t     r;
        int       lane;
        int       size;
        int       exp_stall;
        int       stalls;
        bit       mis;
        bit       done;
        lane = int'(cw.rd_data % 4);
        size = int'(cw.mem_size);
        mis  = (size == 1 && lane % 2 != 0) || (size == 2 && lane != 0);
        e.cw = cw;
        e.mis = 1'b0;
        e.berr = 1'b0;
        exp_stall = 0;
        if (cw.mem_read || cw.mem_write) begin
            if (mis) begin
                e.cw.rd_we   = 1'b0;
                e.cw.rd_data = '0;
                e.mis        = 1'b1;
            end else begin
                rq.addr = cw.rd_data - 32'(lane);
                rq.we   = cw.mem_write;
                if (!cw.mem_write) begin
                    rq.be    = 4'hF;
                    rq.wdata = '0;
                end else if (size == 0) begin
                    rq.be    = 4'(1 << lane);
                    rq.wdata = (cw.rs2_data % 256) * 32'h0101_0101;
                end else if (size == 1) begin
                    rq.be    = 4'(3 << lane);
                    rq.wdata = (cw.rs2_data % 65536) * 32'h0001_0001;
                end else begin
                    rq.be    = 4'hF;
                    rq.wdata = cw.rs2_data;
                end
                r.delay = delay;
                r.rdata = rdata;
                if (delay < 0) begin
                    e.cw.rd_we = 1'b0;
                    e.berr     = 1'b1;
                    exp_stall  = TIMEOUT_CYC;
                end else begin
                    exp_stall = 1 + delay;
                    if (!cw.mem_write) e.cw.rd_data = ref_load(rdata, lane, size, cw.mem_unsigned);
                end
                req_q.push_back(rq);
                rsp_q.push_back(r);
            end
        end
        wb_q.push_back(e);
        ex_mem_cword = cw;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            else done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL stall_bound: got stall still high expected release within 200 cycles");
        end
        chk("stall_cycles", 128'(stalls), 128'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        if (rst_n && (mem_wb_cword != '0 || misalign_err || bus_err)) begin
            if (wb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL wb_unexpected: got %0h expected no output", mem_wb_cword);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                chk("wb_cword", mem_wb_cword, e.cw);
                chk("misalign_err", 128'(misalign_err), 128'(e.mis));
                chk("bus_err", 128'(bus_err), 128'(e.berr));
            end
        end
    end

    // Data-memory responder: checks each new request, then acks per the
    // response queue. Acks while no request is pending are noise.
    initial begin
        bit       active;
        int       cyc;
        rsp_t     r;
        req_exp_t rq;
        active = 1'b0;
        cyc = 0;
        r.delay = 0;
        r.rdata = '0;
        rq = '{default: '0};
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = $urandom;
            if (dmem.dmem_req) begin
                if (!active) begin
                    active = 1'b1;
                    cyc = 0;
                    if (req_q.size() == 0 || rsp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL req_unexpected: got addr %0h expected no request", dmem.dmem_addr);
                        r.delay = 0;
                        r.rdata = '0;
                        rq.addr = dmem.dmem_addr;
                    end else begin
                        rq = req_q.pop_front();
                        r  = rsp_q.pop_front();
                        chk("req_we", 128'(dmem.dmem_we), 128'(rq.we));
                        chk("req_be", 128'(dmem.dmem_be), 128'(rq.be));
                        if (rq.we) chk("req_wdata", 128'(dmem.dmem_wdata), 128'(rq.wdata));
                    end
                end
                chk("req_addr", 128'(dmem.dmem_addr), 128'(rq.addr));
                if (cyc == r.delay) begin
                    dmem.dmem_ack   = 1'b1;
                    dmem.dmem_rdata = r.rdata;
                    active = 1'b0;
                end
                cyc++;
            end else begin
                if (active && r.delay == -1) chk("timeout_req_cycles", 128'(cyc), 128'(TIMEOUT_CYC));
                active = 1'b0;
                dmem.dmem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rvga_cword cw;
        int        kind;
        int        delay;
        ex_mem_cword = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb", mem_wb_cword, '0);
        chk("rst_req", 128'(dmem.dmem_req), 128'(0));
        chk("rst_we", 128'(dmem.dmem_we), 128'(0));
        chk("rst_addr", 128'(dmem.dmem_addr), 128'(0));
        chk("rst_wdata", 128'(dmem.dmem_wdata), 128'(0));
        chk("rst_be", 128'(dmem.dmem_be), 128'(0));
        chk("rst_errs", 128'({misalign_err, bus_err}), 128'(0));
        chk("rst_stall", 128'(mem_stall), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue(mk_cw(0, 0, 32'h0000_1234, 32'h0, 1'b0), 0, '0);
        issue(mk_cw(1, 0, 32'h0000_0103, 32'h0, 1'b0), 0, 32'h80FF_0000);
        issue(mk_cw(1, 0, 32'h0000_0103, 32'h0, 1'b1), 0, 32'h80FF_0000);
        issue(mk_cw(2, 1, 32'h0000_0102, 32'hABCD_1234, 1'b0), 0, '0);
        issue(mk_cw(1, 2, 32'h0000_0102, 32'h0, 1'b0), 0, '0);
        issue(mk_cw(1, 2, 32'h0000_0100, 32'h0, 1'b0), -1, '0);
        issue(mk_cw(1, 1, 32'h0000_0106, 32'h0, 1'b0), 2, 32'h9ABC_1234);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind  = $urandom_range(0, 2);
            delay = ($urandom_range(0, 29) == 0) ? -1 : $urandom_range(0, 4);
            cw = mk_cw(kind, $urandom_range(0, 2), 32'h1000 + $urandom_range(0, 255),
                       $urandom, 1'($urandom_range(0, 1)));
            if (kind == 0) cw.rd_data = $urandom;
            issue(cw, delay, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                ex_mem_cword = '0;
                @(posedge clk);
                #1;
            end
        end

        // Reset while BUSY kills the access without writeback
        cw = mk_cw(1, 2, 32'h0000_0200, 32'h0, 1'b0);
        req_q.push_back('{addr: 32'h0000_0200, we: 1'b0, be: 4'hF, wdata: '0});
        rsp_q.push_back('{delay: -2, rdata: '0});
        ex_mem_cword = cw;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_req", 128'(dmem.dmem_req), 128'(0));
        chk("rst_busy_wb", mem_wb_cword, '0);
        ex_mem_cword = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(mk_cw(1, 2, 32'h0000_0204, 32'h0, 1'b0), 1, 32'hCAFE_F00D);

        ex_mem_cword = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("wb_queue_empty", 128'(wb_q.size()), 128'(0));
        chk("req_queue_empty", 128'(req_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
